// File: rtl/switch_sampler_if.sv
// rtl/switch_sampler_if.sv - CPU-facing data handshake of the switch sampler
// Ports:
//   din       - last accepted stable switch word (sampler -> CPU)
//   din_valid - din holds a word the CPU has not yet consumed (sampler -> CPU)
//   din_ack   - CPU consume strobe (CPU -> sampler)
// Modports: master = sampler side, slave = CPU side.
interface switch_sampler_if;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ack;

    modport master (
        output din,
        output din_valid,
        input  din_ack
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ack
    );
endinterface

// File: rtl/switch_sampler.sv
// rtl/switch_sampler.sv - synchronizes and debounces a 32-bit switch word for the CPU
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high
//   switches   - raw switch word, asynchronous to clk
//   sample_en  - debounce tick qualifier (tie high to count every cycle)
//   cpu        - switch_sampler_if.master: din / din_valid out, din_ack in
//   busy       - high while a candidate word is being timed
//   glitch_cnt - saturating count of aborted settling windows
module switch_sampler #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             switches,
    input  logic                    sample_en,
    switch_sampler_if.master        cpu,
    output logic                    busy,
    output logic [7:0]              glitch_cnt
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    // Counter value on which the final qualifying tick lands.
    localparam logic [15:0] LP_CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_q1;
    logic [31:0] r_q2;
    logic [31:0] r_cand;
    logic [31:0] w_cand_nxt;
    logic [31:0] r_din;
    logic        r_din_valid;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [7:0]  r_glitch;
    logic        w_accept;
    logic        w_glitch;

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_glitch    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_q2 != r_din) begin
                    w_cand_nxt  = r_q2;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = ST_SETTLING;
                end
            end
            ST_SETTLING: begin
                if (r_q2 != r_cand) begin
                    // Input moved before the window closed: restart timing on the new word.
                    w_cand_nxt = r_q2;
                    w_cnt_nxt  = 16'd0;
                    w_glitch   = 1'b1;
                end else if (r_cand == r_din) begin
                    // Bounced back to the accepted word; nothing new to report.
                    w_state_nxt = ST_IDLE;
                end else if (sample_en) begin
                    if (r_cnt == LP_CNT_LAST) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_q1        <= 32'h0;
            r_q2        <= 32'h0;
            r_cand      <= 32'h0;
            r_cnt       <= 16'd0;
            r_din       <= 32'h0;
            r_din_valid <= 1'b0;
            r_glitch    <= 8'h0;
        end else begin
            r_q1    <= switches;
            r_q2    <= r_q1;
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_din <= r_cand;
            end
            // A fresh word wins over a same-edge acknowledge.
            if (w_accept) begin
                r_din_valid <= 1'b1;
            end else if (cpu.din_ack) begin
                r_din_valid <= 1'b0;
            end
            if (w_glitch && (r_glitch != 8'hFF)) begin
                r_glitch <= r_glitch + 8'd1;
            end
        end
    end

    assign cpu.din       = r_din;
    assign cpu.din_valid = r_din_valid;
    assign busy          = (r_state == ST_SETTLING);
    assign glitch_cnt    = r_glitch;

endmodule

// File: tb/tb_switch_sampler.sv
// tb/tb_switch_sampler.sv - scoreboard bench for switch_sampler with a run-length reference model
module tb_switch_sampler;

    localparam int P_DC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] switches;
    logic        sample_en;
    logic        busy;
    logic [7:0]  glitch_cnt;

    always #5 clk = ~clk;

    switch_sampler_if u_if ();

    switch_sampler #(.DEBOUNCE_CYCLES(P_DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .switches   (switches),
        .sample_en  (sample_en),
        .cpu        (u_if),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    typedef struct {
        logic [31:0] word;
        logic [7:0]  glitch;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    bit mon_on = 1'b0;

    // Reference model: the switch word seen after a 2-cycle delay line, described as runs
    // of unchanged value; a run different from the accepted word that survives P_DC ticks
    // becomes the accepted word.
    logic [31:0] m_q1, m_q2, m_acc, m_run;
    bit          m_open, m_valid;
    int          m_ticks, m_glitch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit rst, input logic [31:0] sw, input bit en, input bit ack);
        logic [31:0] seen;
        bit          took;
        if (rst) begin
            m_q1 = 0; m_q2 = 0; m_acc = 0; m_run = 0;
            m_open = 0; m_valid = 0; m_ticks = 0; m_glitch = 0;
            return;
        end
        seen = m_q2;
        m_q2 = m_q1;
        m_q1 = sw;
        took = 1'b0;
        if (seen != m_run) begin
            // A new run starts; if a window was still open it is aborted.
            if (m_open && m_glitch < 255) m_glitch++;
            m_run   = seen;
            m_ticks = 0;
            m_open  = 1'b1;
        end else if (m_open) begin
            if (m_run == m_acc) begin
                m_open = 1'b0;
            end else if (en) begin
                m_ticks++;
                if (m_ticks == P_DC) begin
                    m_acc  = m_run;
                    m_open = 1'b0;
                    took   = 1'b1;
                    exp_q.push_back('{m_run, 8'(m_glitch), cyc});
                end
            end
        end
        if (took) m_valid = 1'b1;
        else if (ack) m_valid = 1'b0;
    endtask

    task automatic step(input bit rst, input logic [31:0] sw, input bit en, input bit ack);
        reset          = rst;
        switches       = sw;
        sample_en      = en;
        u_if.din_ack   = ack;
        @(posedge clk);
        cyc++;
        model_edge(rst, sw, en, ack);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a new word is presented, and checks the
    // running outputs against the model every cycle.
    initial begin
        logic [31:0] pd;
        logic        pv;
        exp_t        e;
        pd = 0;
        pv = 0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (u_if.din_valid === 1'b1 && (pv !== 1'b1 || u_if.din !== pd)) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h expected none (cycle %0d)", u_if.din, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", u_if.din, e.word);
                        chk("word_glitch", {24'h0, glitch_cnt}, {24'h0, e.glitch});
                        chk("word_cycle", cyc, e.cyc);
                    end
                end
                chk("din", u_if.din, m_acc);
                chk("din_valid", {31'h0, u_if.din_valid}, {31'h0, m_valid});
                chk("busy", {31'h0, busy}, {31'h0, m_open});
                chk("glitch_cnt", {24'h0, glitch_cnt}, m_glitch);
                pd = u_if.din;
                pv = u_if.din_valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] w1, w2, w3, wx, ws, cur;
        int          lat;
        w1 = 32'h19071110;
        w2 = 32'h19061110;
        wx = w2 ^ 32'h0001_0000;
        w3 = 32'hCAFE_0042;
        ws = 32'h0BAD_F00D;
        reset = 1'b1; switches = 0; sample_en = 0; u_if.din_ack = 0;

        // Power-up reset with the switch word already present.
        step(1, w1, 1, 0);
        mon_on = 1'b1;
        repeat (9) step(1, w1, 1, 0);
        chk("rst_din", u_if.din, 32'h0);
        chk("rst_valid", {31'h0, u_if.din_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_glitch", {24'h0, glitch_cnt}, 32'h0);
        repeat (6) step(0, w1, 1, 0);
        chk("first_valid_not_early", {31'h0, u_if.din_valid}, 32'h0);
        step(0, w1, 1, 0);
        chk("first_din_at_7", u_if.din, w1);
        chk("first_valid_at_7", {31'h0, u_if.din_valid}, 32'h1);
        chk("first_glitch", {24'h0, glitch_cnt}, 32'h0);

        // Acknowledge, then a one-bit change.
        step(0, w1, 1, 1);
        chk("ack_clears_valid", {31'h0, u_if.din_valid}, 32'h0);
        step(0, w2, 1, 0);
        step(0, w2, 1, 0);
        chk("busy_not_before_3", {31'h0, busy}, 32'h0);
        step(0, w2, 1, 0);
        chk("busy_at_3", {31'h0, busy}, 32'h1);
        repeat (3) step(0, w2, 1, 0);
        chk("din_held_while_settling", u_if.din, w1);
        step(0, w2, 1, 0);
        chk("second_din", u_if.din, w2);
        chk("second_valid", {31'h0, u_if.din_valid}, 32'h1);
        step(0, w2, 1, 1);

        // Bit 16 toggling every 2 cycles, then held.
        for (int i = 0; i < 10; i++) begin
            repeat (2) begin
                step(0, (i % 2 == 0) ? wx : w2, 1, 0);
                chk("din_stable_during_toggle", u_if.din, w2);
            end
        end
        repeat (10) step(0, wx, 1, 0);
        chk("toggle_final_din", u_if.din, wx);
        chk("toggle_final_valid", {31'h0, u_if.din_valid}, 32'h1);
        chk("toggle_glitches", {24'h0, glitch_cnt}, 32'd5);
        step(0, wx, 1, 1);

        // 0 -> 1 -> 0 inside the settle window.
        repeat (3) step(1, 32'h0, 1, 0);
        repeat (2) step(0, 32'h1, 1, 0);
        repeat (10) step(0, 32'h0, 1, 0);
        chk("bounce_din", u_if.din, 32'h0);
        chk("bounce_valid", {31'h0, u_if.din_valid}, 32'h0);
        chk("bounce_glitch", {24'h0, glitch_cnt}, 32'd1);
        chk("bounce_idle", {31'h0, busy}, 32'h0);

        // Sparse sample ticks with ack held high across the accept edge.
        lat = -1;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            step(0, w3, (k % 3) == 2, 1);
            if (u_if.din === w3) begin
                lat = k + 1;
                chk("accept_beats_ack", {31'h0, u_if.din_valid}, 32'h1);
            end
        end
        chk("sparse_latency_in_window",
            {31'h0, (lat >= 3 + 3 * P_DC - 2) && (lat <= 3 + 3 * P_DC)}, 32'h1);
        step(0, w3, 1, 0);

        // Reset in the middle of a settling window.
        repeat (4) step(0, ws, 1, 0);
        chk("pre_reset_settling", {31'h0, busy}, 32'h1);
        repeat (3) begin
            step(1, ws, 1, 0);
            chk("midreset_din", u_if.din, 32'h0);
            chk("midreset_valid", {31'h0, u_if.din_valid}, 32'h0);
            chk("midreset_busy", {31'h0, busy}, 32'h0);
        end
        repeat (6) step(0, ws, 1, 0);
        chk("redebounce_not_early", {31'h0, u_if.din_valid}, 32'h0);
        step(0, ws, 1, 0);
        chk("redebounce_din", u_if.din, ws);
        chk("redebounce_valid", {31'h0, u_if.din_valid}, 32'h1);

        // Randomized traffic.
        cur = ws;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 15) begin
                case ($urandom_range(0, 3))
                    0: cur = 32'h0;
                    1: cur = 32'h1;
                    2: cur = cur ^ (32'h1 << $urandom_range(0, 31));
                    default: cur = $urandom;
                endcase
            end
            step($urandom_range(0, 199) == 0, cur, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 3) == 0);
        end
        repeat (5) step(0, cur, 1, 0);
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
